// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared types and constants for the rv32i fetch/decode path.
//  Revision    : 1.0 - initial release
// ============================================================================

package rv32i_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

`default_nettype wire

// File: rtl/fetch_queue_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_ram
//  Description : DEPTH x {pc, instr} storage, 2 write ports, 2 async reads.
//  Revision    : 1.0 - initial release
// ============================================================================

module fetch_queue_ram
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       we0_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr0_i,
    input  fetch_entry_t               wdata0_i,
    input  logic                       we1_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr1_i,
    input  fetch_entry_t               wdata1_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr0_i,
    output fetch_entry_t               rdata0_o,
    input  logic [$clog2(DEPTH)-1:0]   raddr1_i,
    output fetch_entry_t               rdata1_o
);

    fetch_entry_t mem_q [DEPTH];

    // The two write addresses are always consecutive, so they never collide.
    always_ff @(posedge clk) begin
        if (we0_i) begin
            mem_q[waddr0_i] <= wdata0_i;
        end
        if (we1_i) begin
            mem_q[waddr1_i] <= wdata1_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Dual-issue show-ahead instruction fetch queue with flush.
//  Revision    : 1.0 - initial release
// ============================================================================

module fetch_queue
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid0,
    input  logic [31:0]              in_pc0,
    input  logic [31:0]              in_instr0,
    input  logic                     in_valid1,
    input  logic [31:0]              in_pc1,
    input  logic [31:0]              in_instr1,
    output logic                     in_ready,
    output logic                     out_valid0,
    output logic [31:0]              out_pc0,
    output logic [31:0]              out_instr0,
    output logic                     out_valid1,
    output logic [31:0]              out_pc1,
    output logic [31:0]              out_instr1,
    input  logic [1:0]               deq_count,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW-1:0] head_p1, tail_p1;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] enq_n, deq_n;
    logic [1:0]    deq_req;
    logic          enq_ok, we0, we1;
    fetch_entry_t  rd0, rd1;

    assign head_p1 = head_q + AW'(1);
    assign tail_p1 = tail_q + AW'(1);

    always_comb begin
        in_ready = (count_q <= READY_MAX);
        enq_ok   = in_ready && !flush;
        // Slot 1 alone is an illegal pattern; it is dropped with slot 0.
        we0      = enq_ok && in_valid0;
        we1      = we0 && in_valid1;
        enq_n    = CW'(we0) + CW'(we1);
        deq_req  = (deq_count == 2'd3) ? 2'd2 : deq_count;
        deq_n    = (CW'(deq_req) > count_q) ? count_q : CW'(deq_req);

        head_d   = head_q + deq_n[AW-1:0];
        tail_d   = tail_q + enq_n[AW-1:0];
        count_d  = count_q + enq_n - deq_n;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    fetch_queue_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk      (clk),
        .we0_i    (we0),
        .waddr0_i (tail_q),
        .wdata0_i ('{pc: in_pc0, instr: in_instr0}),
        .we1_i    (we1),
        .waddr1_i (tail_p1),
        .wdata1_i ('{pc: in_pc1, instr: in_instr1}),
        .raddr0_i (head_q),
        .rdata0_o (rd0),
        .raddr1_i (head_p1),
        .rdata1_o (rd1)
    );

    // Empty slots present a harmless NOP so decode never sees stale or X data.
    assign out_valid0 = (count_q != '0);
    assign out_valid1 = (count_q >= CW'(2));
    assign out_pc0    = out_valid0 ? rd0.pc    : 32'd0;
    assign out_instr0 = out_valid0 ? rd0.instr : NOP_INSTR;
    assign out_pc1    = out_valid1 ? rd1.pc    : 32'd0;
    assign out_instr1 = out_valid1 ? rd1.instr : NOP_INSTR;
    assign count      = count_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Scoreboard bench for fetch_queue against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_fetch_queue;
    import rv32i_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid0 = 1'b0, in_valid1 = 1'b0;
    logic [31:0]   in_pc0 = '0, in_instr0 = '0, in_pc1 = '0, in_instr1 = '0;
    logic          in_ready;
    logic          out_valid0, out_valid1;
    logic [31:0]   out_pc0, out_instr0, out_pc1, out_instr1;
    logic [1:0]    deq_count = '0;
    logic [CW-1:0] count;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid0  (in_valid0),
        .in_pc0     (in_pc0),
        .in_instr0  (in_instr0),
        .in_valid1  (in_valid1),
        .in_pc1     (in_pc1),
        .in_instr1  (in_instr1),
        .in_ready   (in_ready),
        .out_valid0 (out_valid0),
        .out_pc0    (out_pc0),
        .out_instr0 (out_instr0),
        .out_valid1 (out_valid1),
        .out_pc1    (out_pc1),
        .out_instr1 (out_instr1),
        .deq_count  (deq_count),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cnt;
        bit          rdy;
        bit          v0;
        bit          v1;
        logic [31:0] pc0;
        logic [31:0] i0;
        logic [31:0] pc1;
        logic [31:0] i1;
    } exp_t;

    fetch_entry_t model_q[$];
    exp_t         expq[$];
    int           vectors = 0;
    int           miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an ordered list of entries; outputs are simply its first two.
    task automatic model_step(input bit r, input bit f, input bit v0, input logic [31:0] p0,
                              input logic [31:0] i0, input bit v1, input logic [31:0] p1,
                              input logic [31:0] i1, input logic [1:0] dc);
        exp_t e;
        int   occ;
        int   dn;
        bit   room;
        occ  = model_q.size();
        room = (DEPTH - occ) >= 2;
        dn   = (dc == 2'd3) ? 2 : int'(dc);
        if (dn > occ) dn = occ;
        if (r || f) begin
            model_q.delete();
        end else begin
            repeat (dn) void'(model_q.pop_front());
            if (room && v0) begin
                model_q.push_back('{pc: p0, instr: i0});
                if (v1) model_q.push_back('{pc: p1, instr: i1});
            end
        end
        occ   = model_q.size();
        e.cnt = occ;
        e.rdy = (DEPTH - occ) >= 2;
        e.v0  = occ >= 1;
        e.v1  = occ >= 2;
        e.pc0 = (occ >= 1) ? model_q[0].pc    : 32'd0;
        e.i0  = (occ >= 1) ? model_q[0].instr : NOP_INSTR;
        e.pc1 = (occ >= 2) ? model_q[1].pc    : 32'd0;
        e.i1  = (occ >= 2) ? model_q[1].instr : NOP_INSTR;
        expq.push_back(e);
    endtask

    task automatic drive(input bit r, input bit f, input bit v0, input logic [31:0] p0,
                         input logic [31:0] i0, input bit v1, input logic [31:0] p1,
                         input logic [31:0] i1, input logic [1:0] dc);
        @(negedge clk);
        rst = r; flush = f;
        in_valid0 = v0; in_pc0 = p0; in_instr0 = i0;
        in_valid1 = v1; in_pc1 = p1; in_instr1 = i1;
        deq_count = dc;
        model_step(r, f, v0, p0, i0, v1, p1, i1, dc);
    endtask

    task automatic pair(input logic [31:0] pc, input logic [1:0] dc);
        drive(0, 0, 1, pc, 32'h00100093 + pc, 1, pc + 32'd4, 32'h00200113 + pc, dc);
    endtask

    task automatic idle(input logic [1:0] dc);
        drive(0, 0, 0, 0, 0, 0, 0, 0, dc);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every post-edge sample is compared against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("count",      32'(count),      32'(e.cnt));
                chk("in_ready",   32'(in_ready),   32'(e.rdy));
                chk("out_valid0", 32'(out_valid0), 32'(e.v0));
                chk("out_valid1", 32'(out_valid1), 32'(e.v1));
                chk("out_pc0",    out_pc0,         e.pc0);
                chk("out_instr0", out_instr0,      e.i0);
                chk("out_pc1",    out_pc1,         e.pc1);
                chk("out_instr1", out_instr1,      e.i1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pc;
        // First pair after reset
        do_reset();
        drive(0, 0, 1, 32'h0, 32'h00100093, 1, 32'h4, 32'h00200113, 0);
        // Fill to DEPTH, then an extra pair must be refused
        pair(32'h08, 0);
        pair(32'h10, 0);
        pair(32'h18, 0);
        pair(32'h20, 0);
        // count 7, then dequeue 2 alongside a refused pair
        idle(1);
        pair(32'h40, 2);
        idle(0);
        // Flush at count 5 with enqueue and dequeue pending
        drive(0, 1, 1, 32'h80, 32'h11, 1, 32'h84, 32'h22, 2);
        pair(32'h100, 0);
        // Wrap-around pair straddling the end of storage
        do_reset();
        pair(32'h00, 0);
        pair(32'h08, 0);
        pair(32'h10, 0);
        pair(32'h18, 0);
        idle(2);
        idle(2);
        idle(2);
        pair(32'h20, 0);
        repeat (5) idle(1);
        // Dequeue clamping and mid-run reset
        drive(0, 0, 1, 32'h200, 32'h33, 0, 32'h0, 32'h0, 0);
        idle(2);
        idle(3);
        pair(32'h300, 0);
        pair(32'h308, 0);
        idle(3);
        pair(32'h310, 0);
        pair(32'h318, 0);
        drive(1, 1, 1, 32'h400, 32'h44, 1, 32'h404, 32'h55, 2);
        idle(0);

        // Randomised traffic with alternating fill/drain bias
        pc = 32'h1000;
        for (int n = 0; n < 1500; n++) begin
            bit          r, f, v0, v1;
            logic [1:0]  dc;
            bit          fill_phase;
            fill_phase = ((n / 100) % 2) == 0;
            r  = ($urandom_range(0, 99) == 0);
            f  = ($urandom_range(0, 24) == 0);
            v0 = ($urandom_range(0, 3) != 0);
            v1 = v0 ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
            if (fill_phase) dc = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            else            dc = 2'($urandom_range(0, 3));
            drive(r, f, v0, pc, $urandom, v1, pc + 32'd4, $urandom, dc);
            pc = pc + 32'd8;
        end
        idle(0);
        @(posedge clk);
        #3;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Dual-issue instruction fetch queue between the instruction ports of `simple_memory` (via fetch PC logic) and the decode/issue stage of `rv32i_cpu`. It accepts up to two fetched {pc, instr} pairs per cycle in program order and presents the two oldest entries to decode in show-ahead form. Decode retires 0, 1 or 2 entries per cycle. A redirect from a taken branch or jump in either execute slot empties the queue in one cycle.

## Interface
- `DEPTH`, 8, number of entries; power of two, ≥4.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  redirect from execute; discards all entries and the current enqueue.
- `in_valid0`  in  1  fetch slot 0 valid.
- `in_pc0`  in  32  PC of fetch slot 0.
- `in_instr0`  in  32  instruction of fetch slot 0.
- `in_valid1`  in  1  fetch slot 1 valid; legal only with `in_valid0`.
- `in_pc1`  in  32  PC of fetch slot 1; expected `in_pc0+4`, not checked.
- `in_instr1`  in  32  instruction of fetch slot 1.
- `in_ready`  out  1  queue has ≥2 free entries.
- `out_valid0`  out  1  oldest entry present.
- `out_pc0`  out  32  PC of the oldest entry.
- `out_instr0`  out  32  instruction of the oldest entry.
- `out_valid1`  out  1  second-oldest entry present.
- `out_pc1`  out  32  PC of the second-oldest entry.
- `out_instr1`  out  32  instruction of the second-oldest entry.
- `deq_count`  in  2  entries consumed by decode this cycle (0/1/2).
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage is a circular buffer of DEPTH {pc, instr} entries, addressed by `head` and `tail` pointers of width $clog2(DEPTH).
- `count` is held explicitly and ranges 0..DEPTH.
- Enqueue accepted = `in_ready && !flush`.
  - When accepted, slot 0 is written at `tail` and slot 1 at `tail+1` mod DEPTH.
  - `tail` advances by `in_valid0 + in_valid1`.
  - `in_valid1` without `in_valid0` writes nothing (both dropped).
- Dequeue:
  - The effective count is `min(deq_count, count)`; value 3 is treated as 2.
  - `head` advances by the effective count.
- Occupancy update: `count_next = count + enq_n - deq_n`, where `enq_n` and `deq_n` are the accepted enqueue and effective dequeue amounts.
- `in_ready = (DEPTH - count) >= 2`.
  - It uses the registered count and gives no credit for a same-cycle dequeue.
  - It is independent of `in_valid*`.
- Outputs are combinational reads at `head` and `head+1` (wrap mod DEPTH).
  - `out_valid0 = count≥1`, `out_valid1 = count≥2`.
  - An invalid output slot drives pc = 0 and instr = 32'h00000013 (NOP), never X.
- Flush: `head`, `tail` and `count` go to 0 on the next edge. Same-cycle enqueue and dequeue are ignored.
- Flush takes priority over enqueue and dequeue. Reset takes priority over everything.

## Timing
- Reset: `count`=0, pointers 0, `in_ready`=1, `out_valid0/1`=0, out pc=0, out instr=NOP. Storage contents are not reset.
- Enqueue-to-output latency is 1 cycle: an entry written at edge N is visible on `out_*` after edge N.
- There is no same-cycle bypass from `in_*` to `out_*`.
- Flush at edge N: the queue is empty after N. An enqueue presented in cycle N+1 is visible after N+1.
- Wrap-around: pointer arithmetic is mod DEPTH. A pair may straddle index DEPTH-1 → 0.
- Full (count=DEPTH) or count=DEPTH-1: `in_ready`=0. A simultaneous dequeue takes effect and enqueue resumes next cycle.
- Empty: `deq_count` is ignored and `count` stays 0.
- Simultaneous enqueue 2 and dequeue 2 with count=2: count stays 2, and the outputs show the new pair next cycle.
- Reset mid-operation: the queue is empty on the next edge regardless of `flush` or `in_valid*`.

## Structure
- Add to `rv32i_pkg`:
  - `fetch_entry_t` (packed struct {logic [31:0] pc; logic [31:0] instr;})
  - `NOP_INSTR = 32'h00000013`
- One sub-module, `fetch_queue_ram`: DEPTH×64 storage with 2 write ports (address, enable) and 2 asynchronous read ports.
  - Write ports never collide, because the two write addresses always differ.
- Pointer, count and flush control live in `fetch_queue`.

## Test plan
- Reset, then `in_valid0/1`=1 with pc 0x0/0x4 and instr 0x00100093/0x00200113, `deq_count`=0 → next cycle `count`=2, `out_valid0/1`=1, out pc 0x0/0x4.
- With DEPTH=8, fill with 4 pairs while `deq_count`=0 → `in_ready`=0 at count=8. A further `in_valid` pair is not stored and `count` stays 8.
- With count=7, `deq_count`=2 and `in_valid` pair high → pair not accepted (`in_ready`=0); count=5 next cycle, `in_ready`=1.
- Push 0x0..0x1C, dequeue 6, push pair 0x20/0x24 (writes to indices 0,1 after wrap), drain → PCs emerge in order 0x18, 0x1C, 0x20, 0x24.
- count=5, `flush`=1 with `in_valid` pair and `deq_count`=2 → next cycle count=0, `out_valid0`=0, out instr=0x00000013.
- count=1, `deq_count`=2 → count=0; `deq_count`=3 with count=4 → count=2; `rst` asserted at count=6 → count=0, `in_ready`=1.
